// File: rtl/spi_to_nitta_deserializer_if.sv
// Bus bundle between the SPI receiver side, the deserializer and the NITTA consumer.
`default_nettype none

interface spi_to_nitta_deserializer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int IDX_WIDTH      = 8
);
  logic                      frame_active;
  logic                      spi_ready;
  logic [SPI_DATA_WIDTH-1:0] from_spi;
  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_WIDTH-1:0]     to_nitta;
  logic [IDX_WIDTH-1:0]      word_index;
  logic                      overflow;
  logic                      partial_drop;

  modport slave (
    input  frame_active, spi_ready, from_spi, out_ready,
    output out_valid, to_nitta, word_index, overflow, partial_drop
  );

  modport master (
    output frame_active, spi_ready, from_spi, out_ready,
    input  out_valid, to_nitta, word_index, overflow, partial_drop
  );
endinterface

`default_nettype wire

// File: rtl/spi_to_nitta_deserializer.sv
// Packs SPI subframes into DATA_WIDTH words, tags each with its index in the frame,
// and queues them in a show-ahead FIFO with a valid/ready output.
`default_nettype none

module spi_to_nitta_deserializer #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter bit PAD_PARTIAL    = 1'b0,
  parameter int IDX_WIDTH      = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  spi_to_nitta_deserializer_if.slave bus
);
  localparam int N  = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]        c_last    = CW'(N - 1);
  localparam logic [IDX_WIDTH-1:0] c_idx_max = '1;
  localparam logic [PW:0]          c_depth   = (PW + 1)'(FIFO_DEPTH);

  logic                  r_spi_ready_d;
  logic                  r_frame_active_d;
  logic [CW-1:0]         r_sub_cnt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [IDX_WIDTH-1:0]  r_frame_idx;
  logic                  r_overflow;
  logic                  r_partial_drop;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]  r_mem_idx  [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;

  logic                  w_rise, w_fall, w_accept;
  logic [CW-1:0]         w_cnt;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic [DATA_WIDTH-1:0] w_sr_acc;
  logic [DATA_WIDTH-1:0] w_pad_word;
  logic                  w_word_done, w_partial, w_push_req, w_pop, w_full, w_push;
  logic [DATA_WIDTH-1:0] w_push_data;

  // A frame start seen together with a strobe makes that strobe the first subframe.
  always_comb begin
    w_rise      = bus.frame_active & ~r_frame_active_d;
    w_fall      = ~bus.frame_active & r_frame_active_d;
    w_accept    = bus.spi_ready & ~r_spi_ready_d & bus.frame_active;
    w_cnt       = w_rise ? '0 : r_sub_cnt;
    w_idx       = w_rise ? '0 : r_frame_idx;
    w_word_done = w_accept & (w_cnt == c_last);
    w_partial   = w_fall & (r_sub_cnt != '0);
    w_push_req  = w_word_done | (w_partial & PAD_PARTIAL);
    w_push_data = w_word_done ? w_sr_acc : w_pad_word;
    w_full      = (r_count == c_depth);
    w_pop       = (r_count != '0) & bus.out_ready;
    w_push      = w_push_req & (~w_full | w_pop);
  end

  if (MSB_FIRST) begin : g_msb
    // The k received subframes sit in the low bits; lift them to the top, zero-filling below.
    always_comb begin
      w_sr_acc   = {r_sr[DATA_WIDTH-SPI_DATA_WIDTH-1:0], bus.from_spi};
      w_pad_word = r_sr << (SPI_DATA_WIDTH * (N - int'(r_sub_cnt)));
    end
  end else begin : g_lsb
    // Slices above the received count may hold a stale word and are masked off.
    always_comb begin
      w_sr_acc = r_sr;
      w_sr_acc[int'(w_cnt)*SPI_DATA_WIDTH +: SPI_DATA_WIDTH] = bus.from_spi;
      w_pad_word = r_sr & ~({DATA_WIDTH{1'b1}} << (SPI_DATA_WIDTH * int'(r_sub_cnt)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spi_ready_d    <= 1'b0;
      r_frame_active_d <= 1'b0;
      r_sub_cnt        <= '0;
      r_sr             <= '0;
      r_frame_idx      <= '0;
      r_overflow       <= 1'b0;
      r_partial_drop   <= 1'b0;
    end else begin
      r_spi_ready_d    <= bus.spi_ready;
      r_frame_active_d <= bus.frame_active;
      r_partial_drop   <= w_partial & ~PAD_PARTIAL;
      if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
      if (w_accept) r_sr <= w_sr_acc;

      if (w_fall)
        r_sub_cnt <= '0;
      else if (w_accept)
        r_sub_cnt <= (w_cnt == c_last) ? '0 : w_cnt + 1'b1;
      else if (w_rise)
        r_sub_cnt <= '0;

      // Dropped words still consume an index so the consumer can spot the gap.
      if (w_push_req && (w_idx != c_idx_max))
        r_frame_idx <= w_idx + 1'b1;
      else
        r_frame_idx <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_mem_idx[r_wr_ptr]  <= w_idx;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.out_valid    = (r_count != '0);
    bus.to_nitta     = r_mem_data[r_rd_ptr];
    bus.word_index   = r_mem_idx[r_rd_ptr];
    bus.overflow     = r_overflow;
    bus.partial_drop = r_partial_drop;
  end
endmodule

`default_nettype wire

// File: tb/tb_spi_to_nitta_deserializer.sv
// Bench: two deserializer instances (MSB-first with padding, LSB-first with drop)
// driven with identical stimulus and compared against a frame-level reference model.
`default_nettype none

module tb_spi_to_nitta_deserializer;
  logic       clk = 1'b0;
  logic       rst, fa, rdy, ordy;
  logic [7:0] din;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  spi_to_nitta_deserializer_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .IDX_WIDTH(8)) ifa ();
  spi_to_nitta_deserializer_if #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .IDX_WIDTH(8)) ifb ();

  assign ifa.frame_active = fa;  assign ifb.frame_active = fa;
  assign ifa.spi_ready    = rdy; assign ifb.spi_ready    = rdy;
  assign ifa.from_spi     = din; assign ifb.from_spi     = din;
  assign ifa.out_ready    = ordy; assign ifb.out_ready   = ordy;

  spi_to_nitta_deserializer #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .FIFO_DEPTH(4),
    .MSB_FIRST(1'b1), .PAD_PARTIAL(1'b1), .IDX_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  spi_to_nitta_deserializer #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .FIFO_DEPTH(4),
    .MSB_FIRST(1'b0), .PAD_PARTIAL(1'b0), .IDX_WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference model: bytes of the word in progress plus the expected FIFO contents.
  logic [7:0]  sub[$];
  logic [31:0] qa_w[$], qb_w[$];
  logic [7:0]  qa_i[$], qb_i[$];
  bit m_ofa, m_ofb, m_pdb, pfa, prdy;
  int idxa, idxb;

  function automatic logic [31:0] pack(bit msb);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < sub.size(); i++)
      w |= msb ? (32'(sub[i]) << (8 * (3 - i))) : (32'(sub[i]) << (8 * i));
    return w;
  endfunction

  function automatic void model_edge();
    bit popa, popb, rise, fall, acc, reqa, reqb;
    logic [31:0] wa, wb;
    if (rst) begin
      sub.delete(); qa_w.delete(); qb_w.delete(); qa_i.delete(); qb_i.delete();
      m_ofa = 0; m_ofb = 0; m_pdb = 0; pfa = 0; prdy = 0; idxa = 0; idxb = 0;
      return;
    end
    popa = (qa_w.size() > 0) && ordy;
    popb = (qb_w.size() > 0) && ordy;
    rise = fa && !pfa;
    fall = !fa && pfa;
    acc  = rdy && !prdy && fa;
    reqa = 0; reqb = 0; wa = '0; wb = '0; m_pdb = 0;
    if (rise) begin sub.delete(); idxa = 0; idxb = 0; end
    if (acc) begin
      sub.push_back(din);
      if (sub.size() == 4) begin
        reqa = 1; reqb = 1; wa = pack(1); wb = pack(0); sub.delete();
      end
    end
    if (fall && sub.size() > 0) begin
      reqa = 1; wa = pack(1); m_pdb = 1; sub.delete();
    end
    if (popa) begin void'(qa_w.pop_front()); void'(qa_i.pop_front()); end
    if (popb) begin void'(qb_w.pop_front()); void'(qb_i.pop_front()); end
    if (reqa) begin
      if (qa_w.size() < 4) begin qa_w.push_back(wa); qa_i.push_back(8'(idxa)); end
      else m_ofa = 1;
      if (idxa < 255) idxa++;
    end
    if (reqb) begin
      if (qb_w.size() < 4) begin qb_w.push_back(wb); qb_i.push_back(8'(idxb)); end
      else m_ofb = 1;
      if (idxb < 255) idxb++;
    end
    pfa = fa; prdy = rdy;
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    din = b; rdy = 1'b1;
    repeat (hold) cycle();
    rdy = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; fa = 1'b0; rdy = 1'b0; ordy = 1'b0; din = '0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; fa = 1'b0; rdy = 1'b0; ordy = 1'b0; din = 8'h5A;
    cycle(); cycle();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b exp=0", ifa.out_valid); end
    total++; if (ifa.to_nitta !== 32'h0) begin bad++; $display("FAIL reset_data_a got=%h exp=0", ifa.to_nitta); end
    total++; if (ifa.word_index !== 8'h0) begin bad++; $display("FAIL reset_idx_a got=%h exp=0", ifa.word_index); end
    total++; if ({ifa.overflow, ifa.partial_drop} !== 2'b00) begin bad++; $display("FAIL reset_flags_a got=%b exp=00", {ifa.overflow, ifa.partial_drop}); end
    total++; if ({ifb.out_valid, ifb.overflow, ifb.partial_drop} !== 3'b000 || ifb.to_nitta !== 32'h0) begin
      bad++; $display("FAIL reset_b got=%b/%h exp=000/0", {ifb.out_valid, ifb.overflow, ifb.partial_drop}, ifb.to_nitta); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_assembly(input int hold);
    fa = 1'b1; cycle();
    send_byte(8'hAA, hold); send_byte(8'hBB, hold); send_byte(8'hCC, hold);
    din = 8'hDD; rdy = 1'b1;
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL asm_early_valid hold=%0d got=%b exp=0", hold, ifa.out_valid); end
    cycle();
    total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== 32'hAABBCCDD || ifa.word_index !== 8'd0) begin
      bad++; $display("FAIL asm_msb hold=%0d got=%b/%h/%0d exp=1/aabbccdd/0", hold, ifa.out_valid, ifa.to_nitta, ifa.word_index); end
    total++; if (ifb.out_valid !== 1'b1 || ifb.to_nitta !== 32'hDDCCBBAA || ifb.word_index !== 8'd0) begin
      bad++; $display("FAIL asm_lsb hold=%0d got=%b/%h/%0d exp=1/ddccbbaa/0", hold, ifb.out_valid, ifb.to_nitta, ifb.word_index); end
    repeat (hold - 1) cycle();
    rdy = 1'b0; cycle();
    fa = 1'b0; ordy = 1'b1; cycle();
    ordy = 1'b0; cycle();
    total++; if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
      bad++; $display("FAIL asm_single_word hold=%0d got=%b%b exp=00", hold, ifa.out_valid, ifb.out_valid); end
  endtask

  task automatic test_multiword();
    ordy = 1'b0; fa = 1'b1; cycle();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1 + int'($urandom_range(0, 2)));
    fa = 1'b0; cycle();
    total++; if (qa_w.size() != 2 || qb_w.size() != 2) begin bad++; $display("FAIL multi_model_count got=%0d exp=2", qa_w.size()); end
    for (int k = 0; k < 2; k++) begin
      total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== qa_w[0] || ifa.word_index !== 8'(k)) begin
        bad++; $display("FAIL multi_a k=%0d got=%h/%0d exp=%h/%0d", k, ifa.to_nitta, ifa.word_index, qa_w[0], k); end
      total++; if (ifb.out_valid !== 1'b1 || ifb.to_nitta !== qb_w[0] || ifb.word_index !== 8'(k)) begin
        bad++; $display("FAIL multi_b k=%0d got=%h/%0d exp=%h/%0d", k, ifb.to_nitta, ifb.word_index, qb_w[0], k); end
      ordy = 1'b1; cycle(); ordy = 1'b0;
    end
    total++; if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin bad++; $display("FAIL multi_drained got=%b%b exp=00", ifa.out_valid, ifb.out_valid); end
  endtask

  task automatic test_partial();
    fa = 1'b1; cycle();
    send_byte(8'h11, 1); send_byte(8'h22, 2); send_byte(8'h33, 1);
    fa = 1'b0; cycle();
    total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== 32'h11223300) begin
      bad++; $display("FAIL partial_pad got=%b/%h exp=1/11223300", ifa.out_valid, ifa.to_nitta); end
    total++; if (ifb.out_valid !== 1'b0 || ifb.partial_drop !== 1'b1 || ifa.partial_drop !== 1'b0) begin
      bad++; $display("FAIL partial_drop got=%b/%b/%b exp=0/1/0", ifb.out_valid, ifb.partial_drop, ifa.partial_drop); end
    cycle();
    total++; if (ifb.partial_drop !== 1'b0) begin bad++; $display("FAIL partial_pulse_len got=%b exp=0", ifb.partial_drop); end
    ordy = 1'b1; cycle(); ordy = 1'b0; cycle();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL partial_drain got=%b exp=0", ifa.out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    fa = 1'b1; cycle();
    for (int i = 0; i < 20; i++) send_byte(8'(i * 7 + 3), 1);
    fa = 1'b0; cycle();
    total++; if (ifa.overflow !== 1'b1 || ifb.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b%b exp=11", ifa.overflow, ifb.overflow); end
    for (int k = 0; k < 4; k++) begin
      total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== qa_w[0] || ifa.word_index !== 8'(k)) begin
        bad++; $display("FAIL ovf_keep_a k=%0d got=%h/%0d exp=%h/%0d", k, ifa.to_nitta, ifa.word_index, qa_w[0], k); end
      total++; if (ifb.to_nitta !== qb_w[0] || ifb.word_index !== 8'(k)) begin
        bad++; $display("FAIL ovf_keep_b k=%0d got=%h/%0d exp=%h/%0d", k, ifb.to_nitta, ifb.word_index, qb_w[0], k); end
      ordy = 1'b1; cycle(); ordy = 1'b0;
    end
    total++; if (ifa.out_valid !== 1'b0 || ifa.overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got=%b/%b exp=0/1", ifa.out_valid, ifa.overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fa = 1'b1; cycle();
    for (int i = 0; i < 19; i++) send_byte(8'($urandom), 1);
    din = 8'hE7; rdy = 1'b1; ordy = 1'b1;
    cycle();
    rdy = 1'b0; ordy = 1'b0; cycle();
    fa = 1'b0; cycle();
    total++; if (ifa.overflow !== 1'b0 || ifb.overflow !== 1'b0) begin bad++; $display("FAIL b2b_no_drop got=%b%b exp=00", ifa.overflow, ifb.overflow); end
    for (int k = 1; k < 5; k++) begin
      total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== qa_w[0] || ifa.word_index !== 8'(k)) begin
        bad++; $display("FAIL b2b_a k=%0d got=%h/%0d exp=%h/%0d", k, ifa.to_nitta, ifa.word_index, qa_w[0], k); end
      total++; if (ifb.to_nitta !== qb_w[0] || ifb.word_index !== 8'(k)) begin
        bad++; $display("FAIL b2b_b k=%0d got=%h/%0d exp=%h/%0d", k, ifb.to_nitta, ifb.word_index, qb_w[0], k); end
      ordy = 1'b1; cycle(); ordy = 1'b0;
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    fa = 1'b1; cycle();
    send_byte(8'hF1, 1); send_byte(8'hF2, 1);
    rst = 1'b1; cycle();
    total++; if ({ifa.out_valid, ifa.overflow, ifa.partial_drop} !== 3'b000 || ifa.to_nitta !== 32'h0 || ifa.word_index !== 8'h0) begin
      bad++; $display("FAIL midrst_outputs got=%b/%h/%h exp=000/0/0", {ifa.out_valid, ifa.overflow, ifa.partial_drop}, ifa.to_nitta, ifa.word_index); end
    cycle(); rst = 1'b0;
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
    total++; if (ifa.out_valid !== 1'b1 || ifa.to_nitta !== 32'h01020304 || ifa.word_index !== 8'd0) begin
      bad++; $display("FAIL midrst_word_a got=%b/%h/%0d exp=1/01020304/0", ifa.out_valid, ifa.to_nitta, ifa.word_index); end
    total++; if (ifb.out_valid !== 1'b1 || ifb.to_nitta !== 32'h04030201) begin
      bad++; $display("FAIL midrst_word_b got=%b/%h exp=1/04030201", ifb.out_valid, ifb.to_nitta); end
    fa = 1'b0; ordy = 1'b1; cycle(); ordy = 1'b0; cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 4) fa = ~fa;
      rdy  = ($urandom_range(0, 2) == 0);
      din  = 8'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      cycle();
      total++; if (ifa.out_valid !== (qa_w.size() != 0) || ifb.out_valid !== (qb_w.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", cyc, ifa.out_valid, ifb.out_valid, qa_w.size() != 0, qb_w.size() != 0); end
      if (qa_w.size() != 0) begin
        total++; if (ifa.to_nitta !== qa_w[0] || ifa.word_index !== qa_i[0]) begin
          bad++; $display("FAIL rnd_head_a cyc=%0d got=%h/%0d exp=%h/%0d", cyc, ifa.to_nitta, ifa.word_index, qa_w[0], qa_i[0]); end
      end
      if (qb_w.size() != 0) begin
        total++; if (ifb.to_nitta !== qb_w[0] || ifb.word_index !== qb_i[0]) begin
          bad++; $display("FAIL rnd_head_b cyc=%0d got=%h/%0d exp=%h/%0d", cyc, ifb.to_nitta, ifb.word_index, qb_w[0], qb_i[0]); end
      end
      total++; if ({ifa.overflow, ifb.overflow, ifa.partial_drop, ifb.partial_drop} !== {m_ofa, m_ofb, 1'b0, m_pdb}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {ifa.overflow, ifb.overflow, ifa.partial_drop, ifb.partial_drop}, {m_ofa, m_ofb, 1'b0, m_pdb}); end
    end
  endtask

  initial begin
    test_reset();
    test_assembly(1);
    test_assembly(5);
    test_multiword();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
